cache_controller: RTL and testbench

Direct-mapped, write-through, no-write-allocate cache sitting between the processor's load/store port and the 32K x 32-bit data memory. It serves reads from a 256-line x 4-word store, fills whole lines from the memory's four-word read port on a miss, and forwards every write to memory. It stalls the processor through `cpu_ready` and keeps hit and access counters for performance measurement.

---
 rtl/cache_controller.sv | 149 ++++++++++++++
 tb/tb_cache_controller.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// Direct-mapped write-through, no-write-allocate cache in front of
// a 32K x 32 data memory, with line fill and hit/access counters.
module cache_controller #(
    parameter int MISS_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [14:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_read,
    input  logic        cpu_write,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic [14:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata1,
    input  logic [31:0] mem_rdata2,
    input  logic [31:0] mem_rdata3,
    input  logic [31:0] mem_rdata4,
    output logic [31:0] hit_count,
    output logic [31:0] access_count
);

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    localparam logic [3:0] LOAD = 4'(MISS_LATENCY - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic [14:0] fill_addr;
    logic [255:0] valid;
    logic [4:0]  tags [256];
    logic [31:0] data [256][4];

    logic [4:0]  tag;
    logic [7:0]  idx;
    logic [1:0]  off;
    logic [7:0]  fill_idx;
    logic        hit;
    logic        is_wr;
    logic        is_rd;
    logic        fill_done;
    logic [31:0] fill_word;

    assign tag       = cpu_addr[14:10];
    assign idx       = cpu_addr[9:2];
    assign off       = cpu_addr[1:0];
    assign fill_idx  = fill_addr[9:2];
    assign hit       = valid[idx] && (tags[idx] == tag);
    assign is_wr     = cpu_write;
    assign is_rd     = cpu_read && !cpu_write;
    assign fill_done = (state == FILL) && (cnt == 4'd0);

    always_comb begin
        fill_word = mem_rdata1;
        unique case (fill_addr[1:0])
            2'd0: fill_word = mem_rdata1;
            2'd1: fill_word = mem_rdata2;
            2'd2: fill_word = mem_rdata3;
            2'd3: fill_word = mem_rdata4;
        endcase
    end

    always_comb begin
        cpu_ready = 1'b0;
        cpu_rdata = 32'd0;
        mem_addr  = 15'd0;
        mem_wdata = 32'd0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        unique case (state)
            IDLE: begin
                if (is_wr) begin
                    mem_write = 1'b1;
                    mem_addr  = cpu_addr;
                    mem_wdata = cpu_wdata;
                    cpu_ready = 1'b1;
                end else if (is_rd) begin
                    cpu_ready = hit;
                    if (hit) cpu_rdata = data[idx][off];
                end else begin
                    cpu_ready = 1'b1;
                end
            end
            FILL: begin
                mem_read = 1'b1;
                mem_addr = {fill_addr[14:2], 2'b00};
                if (cnt == 4'd0) begin
                    cpu_ready = 1'b1;
                    if (cpu_read) cpu_rdata = fill_word;
                end
            end
        endcase
    end

    // Control state; the latched fill address makes FILL immune to
    // request changes from the processor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            fill_addr    <= 15'd0;
            valid        <= '0;
            hit_count    <= 32'd0;
            access_count <= 32'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (is_rd && hit) begin
                        hit_count    <= hit_count + 32'd1;
                        access_count <= access_count + 32'd1;
                    end else if (is_rd) begin
                        cnt       <= LOAD;
                        fill_addr <= cpu_addr;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    if (cnt == 4'd0) begin
                        valid[fill_idx] <= 1'b1;
                        access_count    <= access_count + 32'd1;
                        state           <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
            endcase
        end
    end

    // Tag and data storage carry no reset; valid bits gate them.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            tags[fill_idx]    <= fill_addr[14:10];
            data[fill_idx][0] <= mem_rdata1;
            data[fill_idx][1] <= mem_rdata2;
            data[fill_idx][2] <= mem_rdata3;
            data[fill_idx][3] <= mem_rdata4;
        end else if (state == IDLE && is_wr && hit) begin
            data[idx][off] <= cpu_wdata;
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: directed scenarios then
// random traffic against a line-tag model and a reference memory.
module tb_cache_controller;

    localparam int ML = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [14:0] cpu_addr = '0;
    logic [31:0] cpu_wdata = '0;
    logic        cpu_read = 1'b0;
    logic        cpu_write = 1'b0;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic [14:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata1, mem_rdata2, mem_rdata3, mem_rdata4;
    logic [31:0] hit_count;
    logic [31:0] access_count;

    logic [31:0] ram [32768];
    logic [31:0] ref_mem [32768];
    int          ctag [256];
    int unsigned m_hits;
    int unsigned m_acc;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cache_controller #(.MISS_LATENCY(ML)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_rdata1(mem_rdata1), .mem_rdata2(mem_rdata2),
        .mem_rdata3(mem_rdata3), .mem_rdata4(mem_rdata4),
        .hit_count(hit_count), .access_count(access_count)
    );

    assign mem_rdata1 = ram[mem_addr];
    assign mem_rdata2 = ram[15'(mem_addr + 15'd1)];
    assign mem_rdata3 = ram[15'(mem_addr + 15'd2)];
    assign mem_rdata4 = ram[15'(mem_addr + 15'd3)];

    initial begin
        for (int i = 0; i < 32768; i++) ram[i] = i;
        forever begin
            @(posedge clk);
            if (mem_write) ram[mem_addr] <= mem_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) ctag[i] = -1;
        m_hits = 0;
        m_acc = 0;
    endtask

    task automatic check_idle();
        check("idle_ready", {31'd0, cpu_ready}, 32'd1);
        check("idle_rdata", cpu_rdata, 32'd0);
        check("idle_mem_rd", {31'd0, mem_read}, 32'd0);
        check("idle_mem_wr", {31'd0, mem_write}, 32'd0);
        check("idle_mem_addr", {17'd0, mem_addr}, 32'd0);
        check("hit_count", hit_count, m_hits);
        check("access_count", access_count, m_acc);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        cpu_read = 1'b0;
        cpu_write = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_read(input logic [14:0] a);
        bit exp_hit;
        bit done;
        int stalls;
        int mr;
        logic [31:0] rd;
        exp_hit = (ctag[a[9:2]] == int'(a[14:10]));
        done = 0;
        stalls = 0;
        mr = 0;
        rd = '0;
        @(posedge clk);
        #1 cpu_addr = a;
        cpu_read = 1'b1;
        cpu_write = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (mem_read) mr++;
            if (cpu_ready) begin
                done = 1;
                rd = cpu_rdata;
            end else begin
                stalls++;
            end
        end
        check("rd_done", {31'd0, done}, 32'd1);
        check("rd_stalls", stalls, exp_hit ? 0 : ML);
        check("rd_memread_cycles", mr, exp_hit ? 0 : ML);
        check("rd_data", rd, ref_mem[a]);
        @(posedge clk);
        #1 cpu_read = 1'b0;
        m_acc++;
        if (exp_hit) m_hits++;
        ctag[a[9:2]] = int'(a[14:10]);
        @(negedge clk);
        check_idle();
    endtask

    task automatic do_write(input logic [14:0] a, input logic [31:0] d,
                            input bit both);
        @(posedge clk);
        #1 cpu_addr = a;
        cpu_wdata = d;
        cpu_write = 1'b1;
        cpu_read = both;
        @(negedge clk);
        check("wr_ready", {31'd0, cpu_ready}, 32'd1);
        check("wr_mem_write", {31'd0, mem_write}, 32'd1);
        check("wr_mem_read", {31'd0, mem_read}, 32'd0);
        check("wr_mem_addr", {17'd0, mem_addr}, {17'd0, a});
        check("wr_mem_wdata", mem_wdata, d);
        @(posedge clk);
        #1 cpu_write = 1'b0;
        cpu_read = 1'b0;
        ref_mem[a] = d;
        @(negedge clk);
        check_idle();
        check("wr_ram", ram[a], d);
    endtask

    initial begin
        logic [14:0] a;
        int op;
        for (int i = 0; i < 32768; i++) ref_mem[i] = i;
        model_reset();
        #12;
        check_idle();
        rst_n = 1'b1;

        do_read(15'h0400);
        do_read(15'h0403);
        check("t1_hits", hit_count, 32'd1);
        check("t1_acc", access_count, 32'd2);

        do_reset();
        do_read(15'h0400);
        do_read(15'h0800);
        do_read(15'h0400);
        check("t2_hits", hit_count, 32'd0);
        check("t2_acc", access_count, 32'd3);

        do_write(15'h0402, 32'hDEADBEEF, 0);
        do_read(15'h0402);
        check("t3_data", ref_mem[15'h0402], 32'hDEADBEEF);

        do_write(15'h1000, 32'h12345678, 0);
        do_read(15'h1000);

        @(posedge clk);
        #1 cpu_addr = 15'h2000;
        cpu_read = 1'b1;
        @(negedge clk);
        check("rst_t_ready", {31'd0, cpu_ready}, 32'd0);
        @(negedge clk);
        check("rst_fill_mem_read", {31'd0, mem_read}, 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        cpu_read = 1'b0;
        #1;
        model_reset();
        check("rst_mem_read", {31'd0, mem_read}, 32'd0);
        check("rst_hits", hit_count, 32'd0);
        check("rst_acc", access_count, 32'd0);
        check("rst_ready", {31'd0, cpu_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        do_read(15'h2000);
        check("rst_refill", ref_mem[15'h2000], 32'd8192);

        do_read(15'h0401);
        do_write(15'h0401, 32'd7, 1);
        do_read(15'h0401);

        for (int n = 0; n < 200; n++) begin
            a = {3'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 8'($urandom_range(0, 7)), 2'($urandom)};
            op = $urandom_range(0, 9);
            if (op < 3) do_write(a, $urandom, 0);
            else if (op == 3) do_write(a, $urandom, 1);
            else do_read(a);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
